store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
- Decodes RISC-V S-type store instructions and computes the effective address, byte enables and lane-aligned write data.
- Buffers decoded stores in a parametrised FIFO and drains them to the data-memory port over a valid/ready handshake.
- Sits between dispatch and the load/store memory interface.
- Generalised over XLEN (32/64, adding SD) and queue depth; adds flush and illegal-instruction reporting.

Parameters:
XLEN, 32, datapath width; 32 or 64; SD (funct3 011) legal only when XLEN=64
DEPTH, 4, queue entries; power of two, >=2
BEW, XLEN/8, byte-enable width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard all queued entries
in_valid  input  1  store instruction offered
in_ready  output  1  queue can accept (= !full)
inst  input  32  raw instruction
rs1_data  input  XLEN  base register value
rs2_data  input  XLEN  store data register value
mem_valid  output  1  head entry present (= !empty)
mem_ready  input  1  memory accepts head entry
mem_addr  output  XLEN  head effective address
mem_wdata  output  XLEN  head lane-aligned write data
mem_be  output  BEW  head byte enables
illegal  output  1  registered one-cycle pulse for a rejected instruction
count  output  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst=1): read pointer, write pointer and count = 0; mem_valid=0; in_ready=1; illegal=0. Storage contents are don't-care.
- Decode:
  - Instruction is legal when inst[6:0]=0100011 and funct3 inst[14:12] is in {000 SB, 001 SH, 010 SW}, plus 011 SD when XLEN=64.
  - imm = sign-extend({inst[31:25], inst[11:7]}) to XLEN.
  - addr = rs1_data + imm, modulo 2^XLEN.
- Alignment: off = addr[clog2(BEW)-1:0]; size = 1/2/4/8 bytes for SB/SH/SW/SD.
  - be = ((1<<size)-1) << off, truncated to BEW.
  - wdata = (rs2_data masked to size) << (8*off).
- Accept: an enqueue occurs when in_valid && in_ready && legal. The entry is written at the clock edge and is visible on mem_* in the next cycle (1-cycle latency into an empty queue).
- Illegal instruction with in_valid && in_ready: not enqueued; illegal=1 for exactly the next cycle.
- Dequeue occurs when mem_valid && mem_ready. mem_addr, mem_wdata and mem_be must stay stable while mem_valid && !mem_ready.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0; in_valid is ignored and illegal is not raised.
- Empty: mem_valid=0; mem_* outputs hold the last head value (don't-care).
- Pointers wrap modulo DEPTH.
- flush: highest priority. At the next edge count=0, pointers=0, and any same-cycle enqueue and dequeue are dropped. illegal is also suppressed in a flush cycle.
- Reset mid-operation aborts immediately; in-flight entries are lost.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - SH with addr[0]!=0, SW with addr[1:0]!=0, or SD with addr[2:0]!=0 is not enqueued.
  - An extra output misalign (1 bit) pulses for one cycle, registered like illegal.
- Undefined:
  - No misalign port.
  - Misaligned stores are enqueued with off rounded down to natural alignment for the be and wdata computation.
  - mem_addr still carries the full unrounded address.

Decomposition:
- Shared package holds:
  - OPC_STORE = 7'b0100011
  - funct3 constants F3_SB/SH/SW/SD
  - oper_t codes OP_SB/OP_SH/OP_SW/OP_SD/OP_NOP
  - XLEN-derived word_t and be_t typedefs
- Sub-module store_align (combinational) produces legal, op, addr, be, wdata and misaligned from inst, rs1_data and rs2_data. The top level holds only the FIFO and control logic.

Test Plan:
- SW, XLEN=32, rs1=0x1000, imm=-4 (inst 0xFE112E23 pattern), rs2=0xDEADBEEF -> next cycle mem_valid=1, addr=0x0FFC, be=1111, wdata=0xDEADBEEF.
- SB with addr=0x1003, rs2=0x000000AB -> be=1000, wdata=0xAB000000; SH with addr=0x1002, rs2=0x1234 -> be=1100, wdata=0x12340000.
- DEPTH=4, mem_ready=0, five back-to-back valid SW -> count reaches 4, in_ready=0, fifth not accepted; raise mem_ready -> four entries drain in FIFO order, one per cycle.
- Full queue with in_valid and mem_ready both high -> exactly one dequeue, no enqueue that cycle, count 4 then 3.
- funct3=011 with XLEN=32, or opcode 0110011 -> not enqueued, illegal high exactly one cycle, count unchanged; XLEN=64 SD at addr 0x8 -> be=0xFF.
- Queue holding 3 entries, flush asserted together with a valid SW -> next cycle count=0, mem_valid=0, illegal=0; with MISALIGN_TRAP_EN, SW at 0x1002 -> misalign pulse, no enqueue.

Source files
------------

// File: rtl/store_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_pkg
//  Description : Shared decode constants, operation codes and datapath types
//                for the store queue and its address/lane alignment unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_queue_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [2:0] {
        OP_SB  = 3'd0,
        OP_SH  = 3'd1,
        OP_SW  = 3'd2,
        OP_SD  = 3'd3,
        OP_NOP = 3'd7
    } oper_t;

    // Default-configuration datapath types; modules built with another XLEN
    // declare their vectors from their own parameter.
    localparam int XLEN_DEFAULT = 32;
    typedef logic [XLEN_DEFAULT-1:0]   word_t;
    typedef logic [XLEN_DEFAULT/8-1:0] be_t;

    // log2 of the access size in bytes (SB=0 .. SD=3); NOP maps to a byte.
    function automatic logic [1:0] size_log2(input oper_t op);
        case (op)
            OP_SH:   return 2'd1;
            OP_SW:   return 2'd2;
            OP_SD:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_queue_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_align
//  Description : Combinational S-type store decode: legality, effective
//                address, byte enables, lane-aligned write data and natural
//                alignment check. Byte lanes are always computed from the
//                offset rounded down to natural alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_align
    import store_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              legal,
    output oper_t             op,
    output logic [XLEN-1:0]   addr,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic              misaligned
);

    localparam int BEW  = XLEN / 8;
    localparam int OFFW = $clog2(BEW);

    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm;
    logic [1:0]      w_size_log2;
    logic [3:0]      w_size_mask;
    logic [OFFW-1:0] w_off;
    logic [OFFW-1:0] w_off_mask;
    logic [OFFW-1:0] w_off_al;
    logic [XLEN-1:0] w_data_masked;
    logic            w_unused_fields;

    assign w_funct3 = inst[14:12];
    assign w_imm    = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign addr     = rs1_data + w_imm;

    // Register-number fields are resolved upstream; only the values arrive here.
    assign w_unused_fields = ^{inst[24:15], w_size_mask};

    // Opcode/funct3 decode; SD exists only on a 64-bit datapath
    always_comb begin
        op = OP_NOP;
        if (inst[6:0] == OPC_STORE) begin
            case (w_funct3)
                F3_SB:   op = OP_SB;
                F3_SH:   op = OP_SH;
                F3_SW:   op = OP_SW;
                F3_SD:   op = (XLEN == 64) ? OP_SD : OP_NOP;
                default: op = OP_NOP;
            endcase
        end
    end

    assign legal       = (op != OP_NOP);
    assign w_size_log2 = size_log2(op);
    assign w_size_mask = (4'd1 << w_size_log2) - 4'd1;
    assign w_off       = addr[OFFW-1:0];
    assign w_off_mask  = w_size_mask[OFFW-1:0];
    assign w_off_al    = w_off & ~w_off_mask;
    assign misaligned  = legal && ((w_off & w_off_mask) != '0);

    // Keep only the bytes of the access size and mark the lanes they occupy
    always_comb begin
        w_data_masked = '0;
        be            = '0;
        for (int i = 0; i < BEW; i++) begin
            if (i < (1 << w_size_log2)) begin
                w_data_masked[8*i +: 8] = rs2_data[8*i +: 8];
            end
            if ((i >= int'(w_off_al)) && (i < (int'(w_off_al) + (1 << w_size_log2)))) begin
                be[i] = 1'b1;
            end
        end
    end

    assign wdata = w_data_masked << {w_off_al, 3'b000};

endmodule
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue
//  Description : Decodes S-type stores and buffers them in a DEPTH-entry FIFO
//                drained to the data-memory port by valid/ready handshake.
//                Flush has highest priority. Optional macro MISALIGN_TRAP_EN
//                rejects misaligned stores and reports them on 'misalign'.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_queue
    import store_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [XLEN-1:0]            mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_be,
    output logic                       illegal,
`ifdef MISALIGN_TRAP_EN
    output logic                       misalign,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int BEW = XLEN / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    logic            w_legal;
    oper_t           w_op;
    logic [XLEN-1:0] w_addr;
    logic [BEW-1:0]  w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_misaligned;
    logic            w_unused_align;

    logic            w_full;
    logic            w_offer;
    logic            w_trap;
    logic            w_enq;
    logic            w_deq;

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_illegal;
    logic            r_misalign;

    logic [XLEN-1:0] r_addr_q  [DEPTH];
    logic [XLEN-1:0] r_wdata_q [DEPTH];
    logic [BEW-1:0]  r_be_q    [DEPTH];

    store_align #(
        .XLEN (XLEN)
    ) u_align (
        .inst       (inst),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .legal      (w_legal),
        .op         (w_op),
        .addr       (w_addr),
        .be         (w_be),
        .wdata      (w_wdata),
        .misaligned (w_misaligned)
    );

    // The operation code is folded into be/wdata already.
    assign w_unused_align = ^{w_op, w_misaligned, r_misalign};

`ifdef MISALIGN_TRAP_EN
    assign w_trap   = w_misaligned;
    assign misalign = r_misalign;
`else
    assign w_trap   = 1'b0;
`endif

    assign w_full    = (r_count == CW'(DEPTH));
    assign in_ready  = !w_full;
    assign mem_valid = (r_count != '0);

    // An offered instruction is only looked at when there is room and no flush
    assign w_offer = in_valid && in_ready && !flush;
    assign w_enq   = w_offer && w_legal && !w_trap;
    assign w_deq   = mem_valid && mem_ready && !flush;

    // Pointer, occupancy and status-pulse state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_illegal  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_illegal  <= w_offer && !w_legal;
            r_misalign <= w_offer && w_legal && w_misaligned;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_q[r_wr_ptr]  <= w_addr;
            r_wdata_q[r_wr_ptr] <= w_wdata;
            r_be_q[r_wr_ptr]    <= w_be;
        end
    end

    assign mem_addr  = r_addr_q[r_rd_ptr];
    assign mem_wdata = r_wdata_q[r_rd_ptr];
    assign mem_be    = r_be_q[r_rd_ptr];
    assign illegal   = r_illegal;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_queue
//  Description : Directed, table-driven bench for store_queue (XLEN=32,
//                DEPTH=4) plus a 64-bit instance for the SD lane checks.
//                Optional macro MISALIGN_TRAP_EN selects the trap variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        illegal;
    logic [2:0]  count;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] inst64 = '0;
    logic [63:0] rs1_64 = '0;
    logic [63:0] rs2_64 = '0;
    logic        mem_valid64;
    logic        mem_ready64 = 1'b0;
    logic [63:0] mem_addr64;
    logic [63:0] mem_wdata64;
    logic [7:0]  mem_be64;
    logic        illegal64;
    logic [2:0]  count64;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic        misalign64;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .illegal(illegal),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .count(count)
    );

    store_queue #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst(inst64), .rs1_data(rs1_64), .rs2_data(rs2_64),
        .mem_valid(mem_valid64), .mem_ready(mem_ready64), .mem_addr(mem_addr64),
        .mem_wdata(mem_wdata64), .mem_be(mem_be64), .illegal(illegal64),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign64),
`endif
        .count(count64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        legal;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] s_inst(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd1, 5'd2, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        inst = v.inst; rs1_data = v.rs1; rs2_data = v.rs2;
        in_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_mem_valid"}, 64'(mem_valid), 64'(v.legal));
        chk({nm, "_illegal"}, 64'(illegal), 64'(!v.legal));
        chk({nm, "_count"}, 64'(count), v.legal ? 64'd1 : 64'd0);
        if (v.legal) begin
            chk({nm, "_addr"}, 64'(mem_addr), 64'(v.addr));
            chk({nm, "_be"}, 64'(mem_be), 64'(v.be));
            chk({nm, "_wdata"}, 64'(mem_wdata), 64'(v.wdata));
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({nm, "_drained"}, 64'(count), 64'd0);
        chk({nm, "_illegal_off"}, 64'(illegal), 64'd0);
    endtask

    // Offer one SW per cycle for n cycles, data tagged by base
    task automatic push_sw(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            inst = s_inst(12'h000, 3'b010);
            rs1_data = base + 32'(4 * k);
            rs2_data = 32'hA0 + 32'(k);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic misalign_case(input string nm, input logic [31:0] i, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wdata);
        @(negedge clk);
        inst = i; rs1_data = r1; rs2_data = r2; in_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_illegal"}, 64'(illegal), 64'd0);
`ifdef MISALIGN_TRAP_EN
        chk({nm, "_misalign"}, 64'(misalign), 64'd1);
        chk({nm, "_count"}, 64'(count), 64'd0);
        chk({nm, "_mem_valid"}, 64'(mem_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_misalign_off"}, 64'(misalign), 64'd0);
`else
        chk({nm, "_count"}, 64'(count), 64'd1);
        chk({nm, "_addr"}, 64'(mem_addr), 64'(r1));
        chk({nm, "_be"}, 64'(mem_be), 64'(exp_be));
        chk({nm, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
`endif
    endtask

    task automatic apply64(input string nm, input logic [31:0] i, input logic [63:0] r1,
                           input logic [63:0] r2, input logic legal, input logic [63:0] exp_addr,
                           input logic [7:0] exp_be, input logic [63:0] exp_wdata);
        @(negedge clk);
        inst64 = i; rs1_64 = r1; rs2_64 = r2; in_valid64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        chk({nm, "_mem_valid"}, 64'(mem_valid64), 64'(legal));
        chk({nm, "_illegal"}, 64'(illegal64), 64'(!legal));
        if (legal) begin
            chk({nm, "_addr"}, mem_addr64, exp_addr);
            chk({nm, "_be"}, 64'(mem_be64), 64'(exp_be));
            chk({nm, "_wdata"}, mem_wdata64, exp_wdata);
        end
        mem_ready64 = 1'b1;
        @(negedge clk);
        mem_ready64 = 1'b0;
        chk({nm, "_drained"}, 64'(count64), 64'd0);
    endtask

    initial begin
        //            inst                       rs1           rs2           lg   addr          be     wdata
        vecs[0] = '{32'hFE112E23,              32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0FFC, 4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{s_inst(12'h003, 3'b000),   32'h0000_1000, 32'h0000_00AB, 1'b1, 32'h0000_1003, 4'h8, 32'hAB00_0000};
        vecs[2] = '{s_inst(12'h002, 3'b001),   32'h0000_1000, 32'hFFFF_1234, 1'b1, 32'h0000_1002, 4'hC, 32'h1234_0000};
        vecs[3] = '{s_inst(12'h000, 3'b000),   32'h0000_2001, 32'h1122_3344, 1'b1, 32'h0000_2001, 4'h2, 32'h0000_4400};
        vecs[4] = '{s_inst(12'h800, 3'b001),   32'h8000_0000, 32'h0000_ABCD, 1'b1, 32'h7FFF_F800, 4'h3, 32'h0000_ABCD};
        vecs[5] = '{s_inst(12'h004, 3'b010),   32'hFFFF_FFFC, 32'h0102_0304, 1'b1, 32'h0000_0000, 4'hF, 32'h0102_0304};
        vecs[6] = '{s_inst(12'h000, 3'b011),   32'h0000_0008, 32'h1111_1111, 1'b0, 32'h0,          4'h0, 32'h0};
        vecs[7] = '{32'h0020_81B3,             32'h0000_0008, 32'h2222_2222, 1'b0, 32'h0,          4'h0, 32'h0};
        vecs[8] = '{s_inst(12'h000, 3'b100),   32'h0000_0008, 32'h3333_3333, 1'b0, 32'h0,          4'h0, 32'h0};

        // Reset state
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Five back-to-back SW with memory stalled: fills at four, fifth dropped
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inst = s_inst(12'h000, 3'b010);
            rs1_data = 32'h100 + 32'(4 * k);
            rs2_data = 32'hA0 + 32'(k);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("fill_count%0d", k), 64'(count), (k < 4) ? 64'(k + 1) : 64'd4);
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_illegal", 64'(illegal), 64'd0);
        // Illegal instruction while full is ignored
        inst = 32'h0020_81B3;
        @(negedge clk);
        chk("full_illegal_ignored", 64'(illegal), 64'd0);
        chk("full_head_stable", 64'(mem_addr), 64'h100);
        // Full with in_valid and mem_ready: one dequeue, no enqueue
        inst = s_inst(12'h000, 3'b010);
        rs1_data = 32'h200; rs2_data = 32'hEE;
        mem_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_deq_count", 64'(count), 64'd3);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain_addr%0d", k), 64'(mem_addr), 64'(32'h100 + 32'(4 * k)));
            chk($sformatf("drain_wdata%0d", k), 64'(mem_wdata), 64'(32'hA0 + 32'(k)));
            @(negedge clk);
            chk($sformatf("drain_count%0d", k), 64'(count), 64'(3 - k));
        end
        chk("drain_empty", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;

        // Simultaneous enqueue and dequeue on a non-full queue
        push_sw(1, 32'h300);
        chk("sim_pre_count", 64'(count), 64'd1);
        inst = s_inst(12'h000, 3'b010);
        rs1_data = 32'h304; rs2_data = 32'h44;
        in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sim_count", 64'(count), 64'd1);
        chk("sim_head", 64'(mem_addr), 64'h304);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("sim_drained", 64'(count), 64'd0);

        // Flush with three queued entries and a same-cycle valid SW
        push_sw(3, 32'h400);
        chk("flush_pre_count", 64'(count), 64'd3);
        inst = s_inst(12'h000, 3'b010);
        rs1_data = 32'h4F0;
        in_valid = 1'b1; mem_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_mem_valid", 64'(mem_valid), 64'd0);
        chk("flush_illegal", 64'(illegal), 64'd0);
        // Flush suppresses an illegal report too
        inst = 32'h0020_81B3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        chk("flush_illegal_supp", 64'(illegal), 64'd0);
        chk("flush_count2", 64'(count), 64'd0);
        // Pointers restart from zero after flush
        push_sw(1, 32'h500);
        chk("post_flush_head", 64'(mem_addr), 64'h500);
        chk("post_flush_count", 64'(count), 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;

        // Misaligned stores
        misalign_case("mis_sw", s_inst(12'h000, 3'b010), 32'h1002, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        misalign_case("mis_sh", s_inst(12'h000, 3'b001), 32'h1001, 32'h0000_BEEF, 4'h3, 32'h0000_BEEF);

        // Asynchronous reset mid-operation
        push_sw(2, 32'h600);
        chk("arst_pre_count", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_mem_valid", 64'(mem_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 64-bit datapath
        apply64("sd_64", s_inst(12'h000, 3'b011), 64'h8, 64'h1122_3344_5566_7788, 1'b1,
                64'h8, 8'hFF, 64'h1122_3344_5566_7788);
        apply64("sw_64", s_inst(12'h004, 3'b010), 64'h8, 64'hFFFF_FFFF_89AB_CDEF, 1'b1,
                64'hC, 8'hF0, 64'h89AB_CDEF_0000_0000);
        apply64("sb_64", s_inst(12'hFFF, 3'b000), 64'h6, 64'h0000_0000_0000_0177, 1'b1,
                64'h5, 8'h20, 64'h0000_7700_0000_0000);
        apply64("f3_100_64", s_inst(12'h000, 3'b100), 64'h8, 64'h0, 1'b0,
                64'h0, 8'h0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
